// File: rtl/led18_seq_ctrl.sv
// LED pattern sequencer acting as an Avalon-MM master on the LED PIO register 0.
// Optional readback check of every write: define LED18_READBACK_VERIFY_EN.
`timescale 1ns/1ps
module led18_seq_ctrl #(
   parameter int               WIDTH          = 18,
   parameter int               DIV_W          = 24,
   parameter logic [DIV_W-1:0] DEFAULT_PERIOD = 24'd5000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_mode,
   input  logic [WIDTH-1:0] cfg_pattern,
   input  logic [DIV_W-1:0] cfg_period,
   output logic             pio_chipselect,
   output logic             pio_write_n,
   output logic [1:0]       pio_address,
   output logic [WIDTH-1:0] pio_writedata,
   input  logic [WIDTH-1:0] pio_readdata,
   output logic [WIDTH-1:0] cur_pattern,
   output logic             busy,
   output logic             err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_WRITE = 2'd2,
      ST_READ  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_STATIC = 2'd0;
   localparam logic [1:0] MODE_ROT_L  = 2'd1;
   localparam logic [1:0] MODE_ROT_R  = 2'd2;
   localparam logic [1:0] MODE_BOUNCE = 2'd3;
   localparam logic       DIR_LEFT    = 1'b0;
   localparam logic       DIR_RIGHT   = 1'b1;

`ifdef LED18_READBACK_VERIFY_EN
   localparam logic       READBACK    = 1'b1;
`else
   localparam logic       READBACK    = 1'b0;
`endif

   // The READ cycle after every write means two cycles is the shortest achievable step.
   localparam logic [DIV_W-1:0] MIN_PERIOD = READBACK ? DIV_W'(32'd2) : DIV_W'(32'd1);
   localparam logic [DIV_W-1:0] ONE        = DIV_W'(32'd1);
   localparam logic [DIV_W-1:0] ZERO       = DIV_W'(32'd0);

   function automatic logic [DIV_W-1:0] clamp_period(input logic [DIV_W-1:0] p);
      return (p < MIN_PERIOD) ? MIN_PERIOD : p;
   endfunction

   // Returns {direction, pattern}; a bounce flip and its shift happen in the same step.
   function automatic logic [WIDTH:0] step_pattern(input logic [1:0] mode,
                                                   input logic [WIDTH-1:0] p,
                                                   input logic dir);
      logic [WIDTH:0] r;
      case (mode)
         MODE_ROT_L: r = {dir, p[WIDTH-2:0], p[WIDTH-1]};
         MODE_ROT_R: r = {dir, p[0], p[WIDTH-1:1]};
         MODE_BOUNCE: begin
            if (dir == DIR_LEFT) begin
               if (p[WIDTH-1]) r = {DIR_RIGHT, 1'b0, p[WIDTH-1:1]};
               else            r = {DIR_LEFT, p[WIDTH-2:0], 1'b0};
            end else begin
               if (p[0])       r = {DIR_LEFT, p[WIDTH-2:0], 1'b0};
               else            r = {DIR_RIGHT, 1'b0, p[WIDTH-1:1]};
            end
         end
         default: r = {dir, p};
      endcase
      return r;
   endfunction

   state_t             state_r, state_next_s;
   logic [1:0]         mode_r, mode_next_s;
   logic [DIV_W-1:0]   period_r, period_next_s;
   logic [DIV_W-1:0]   cnt_r, cnt_next_s;
   logic [WIDTH-1:0]   pattern_r, pattern_next_s;
   logic               dir_r, dir_next_s;
   logic [WIDTH:0]     stepped_s;
   logic               cfg_fire_s, count_en_s, step_ok_s, step_s;

   logic               cfg_ready_r, cs_r, write_n_r, busy_r;
   logic               cs_next_s, write_n_next_s, busy_next_s, ready_next_s;
   logic [WIDTH-1:0]   writedata_r, cur_pattern_r, writedata_next_s, cur_next_s;

   // Datapath next values: config beats step, counter holds whenever counting is disabled.
   always_comb begin
      cfg_fire_s     = cfg_valid && cfg_ready_r;
      count_en_s     = enable && (mode_r != MODE_STATIC);
      step_ok_s      = READBACK ? (state_r != ST_WRITE) : 1'b1;
      step_s         = count_en_s && (cnt_r == ZERO) && step_ok_s;
      stepped_s      = step_pattern(mode_r, pattern_r, dir_r);
      mode_next_s    = mode_r;
      period_next_s  = period_r;
      pattern_next_s = pattern_r;
      dir_next_s     = dir_r;
      cnt_next_s     = cnt_r;
      if (cfg_fire_s) begin
         mode_next_s    = cfg_mode;
         period_next_s  = clamp_period(cfg_period);
         pattern_next_s = cfg_pattern;
         dir_next_s     = DIR_LEFT;
         cnt_next_s     = clamp_period(cfg_period) - ONE;
      end else if (step_s) begin
         pattern_next_s = stepped_s[WIDTH-1:0];
         dir_next_s     = stepped_s[WIDTH];
         cnt_next_s     = period_r - ONE;
      end else if (count_en_s && (cnt_r != ZERO)) begin
         cnt_next_s     = cnt_r - ONE;
      end else begin
         cnt_next_s     = cnt_r;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_r    <= MODE_STATIC;
         period_r  <= clamp_period(DEFAULT_PERIOD);
         cnt_r     <= clamp_period(DEFAULT_PERIOD) - ONE;
         pattern_r <= {WIDTH{1'b0}};
         dir_r     <= DIR_LEFT;
      end else begin
         mode_r    <= mode_next_s;
         period_r  <= period_next_s;
         cnt_r     <= cnt_next_s;
         pattern_r <= pattern_next_s;
         dir_r     <= dir_next_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_next_s;
   end

   // FSM next state; with a period of 1 a WRITE can chain straight into another WRITE.
   always_comb begin
      state_next_s = ST_IDLE;
      case (state_r)
         ST_IDLE, ST_RUN: begin
            if (cfg_fire_s || step_s) state_next_s = ST_WRITE;
            else if (count_en_s)      state_next_s = ST_RUN;
            else                      state_next_s = ST_IDLE;
         end
         ST_WRITE: begin
            if (READBACK)             state_next_s = ST_READ;
            else if (step_s)          state_next_s = ST_WRITE;
            else if (count_en_s)      state_next_s = ST_RUN;
            else                      state_next_s = ST_IDLE;
         end
         ST_READ: begin
            if (step_s)               state_next_s = ST_WRITE;
            else if (count_en_s)      state_next_s = ST_RUN;
            else                      state_next_s = ST_IDLE;
         end
         default:                     state_next_s = ST_IDLE;
      endcase
   end

   // FSM outputs, decoded from the upcoming state so they can be registered.
   always_comb begin
      cs_next_s        = (state_next_s == ST_WRITE) || (state_next_s == ST_READ);
      write_n_next_s   = (state_next_s != ST_WRITE);
      busy_next_s      = cs_next_s;
      ready_next_s     = !cs_next_s;
      writedata_next_s = writedata_r;
      cur_next_s       = cur_pattern_r;
      if (state_next_s == ST_WRITE) begin
         writedata_next_s = pattern_next_s;
         cur_next_s       = pattern_next_s;
      end else begin
         writedata_next_s = writedata_r;
         cur_next_s       = cur_pattern_r;
      end
   end

   // Output registers; the asynchronous reset drops a strobe in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_r          <= 1'b0;
         write_n_r     <= 1'b1;
         busy_r        <= 1'b0;
         cfg_ready_r   <= 1'b1;
         writedata_r   <= {WIDTH{1'b0}};
         cur_pattern_r <= {WIDTH{1'b0}};
      end else begin
         cs_r          <= cs_next_s;
         write_n_r     <= write_n_next_s;
         busy_r        <= busy_next_s;
         cfg_ready_r   <= ready_next_s;
         writedata_r   <= writedata_next_s;
         cur_pattern_r <= cur_next_s;
      end
   end

   assign pio_chipselect = cs_r;
   assign pio_write_n    = write_n_r;
   assign pio_address    = 2'd0;
   assign pio_writedata  = writedata_r;
   assign cur_pattern    = cur_pattern_r;
   assign busy           = busy_r;
   assign cfg_ready      = cfg_ready_r;

`ifdef LED18_READBACK_VERIFY_EN
   logic err_r;

   // Sticky readback mismatch flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                                     err_r <= 1'b0;
      else if ((state_r == ST_READ) && (pio_readdata != cur_pattern_r)) err_r <= 1'b1;
      else                                                           err_r <= err_r;
   end

   assign err = err_r;
`else
   logic unused_readdata_s;
   assign unused_readdata_s = ^pio_readdata;
   assign err               = 1'b0;
`endif

endmodule

// File: tb/tb_led18_seq_ctrl.sv
// Directed bench for led18_seq_ctrl (default build) with a simple PIO register model.
`timescale 1ns/1ps
module tb_led18_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [1:0]  cfg_mode = 2'd0;
   logic [17:0] cfg_pattern = 18'd0;
   logic [23:0] cfg_period = 24'd0;
   logic        cfg_ready, pio_chipselect, pio_write_n, busy, err;
   logic [1:0]  pio_address;
   logic [17:0] pio_writedata, pio_readdata, cur_pattern;

   logic [17:0] out_port = 18'd0;
   int          edge_cnt = 0;
   logic [17:0] q_data[$];
   int          q_edge[$];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;
   assign pio_readdata = out_port;

   led18_seq_ctrl dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
      .cfg_pattern(cfg_pattern), .cfg_period(cfg_period),
      .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
      .pio_address(pio_address), .pio_writedata(pio_writedata),
      .pio_readdata(pio_readdata), .cur_pattern(cur_pattern),
      .busy(busy), .err(err)
   );

   // PIO register model plus a log of every write strobe and the edge that captured it.
   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      if (pio_chipselect && !pio_write_n) begin
         out_port <= pio_writedata;
         q_data.push_back(pio_writedata);
         q_edge.push_back(edge_cnt);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for ready, then presents one config beat across a single rising edge.
   task automatic cfg_send(input logic [1:0] m, input logic [17:0] p, input logic [23:0] per,
                           input logic en, output int base);
      int waited;
      waited = 0;
      while (!cfg_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!cfg_ready) chk("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
      base        = q_data.size();
      cfg_mode    = m;
      cfg_pattern = p;
      cfg_period  = per;
      enable      = en;
      cfg_valid   = 1'b1;
      @(negedge clk);
      cfg_valid   = 1'b0;
   endtask

   initial begin
      int b, b2;
      logic found;

      repeat (3) @(negedge clk);
      chk("rst_cs",        32'(pio_chipselect), 32'd0);
      chk("rst_write_n",   32'(pio_write_n),    32'd1);
      chk("rst_address",   32'(pio_address),    32'd0);
      chk("rst_writedata", 32'(pio_writedata),  32'd0);
      chk("rst_cur",       32'(cur_pattern),    32'd0);
      chk("rst_busy",      32'(busy),           32'd0);
      chk("rst_err",       32'(err),            32'd0);

      reset  = 1'b0;
      enable = 1'b1;
      repeat (100) @(negedge clk);
      chk("idle_strobes", 32'(q_data.size()), 32'd0);
      chk("idle_write_n", 32'(pio_write_n),   32'd1);
      chk("idle_cur",     32'(cur_pattern),   32'd0);

      // STATIC: one strobe, then silence.
      cfg_send(2'd0, 18'h2AAAA, 24'd10, 1'b1, b);
      chk("st_cs",        32'(pio_chipselect), 32'd1);
      chk("st_write_n",   32'(pio_write_n),    32'd0);
      chk("st_writedata", 32'(pio_writedata),  32'h2AAAA);
      chk("st_cur",       32'(cur_pattern),    32'h2AAAA);
      chk("st_busy",      32'(busy),           32'd1);
      chk("st_ready",     32'(cfg_ready),      32'd0);
      @(negedge clk);
      chk("st_out_port",  32'(out_port),       32'h2AAAA);
      chk("st_cs_done",   32'(pio_chipselect), 32'd0);
      chk("st_ready_back",32'(cfg_ready),      32'd1);
      repeat (200) @(negedge clk);
      chk("st_one_write", 32'(q_data.size() - b), 32'd1);

      // ROT_L every 4 cycles.
      cfg_send(2'd1, 18'h20001, 24'd4, 1'b1, b);
      repeat (14) @(negedge clk);
      chk("rl_d0", 32'(q_data[b]),   32'h20001);
      chk("rl_d1", 32'(q_data[b+1]), 32'h00003);
      chk("rl_d2", 32'(q_data[b+2]), 32'h00006);
      chk("rl_d3", 32'(q_data[b+3]), 32'h0000C);
      chk("rl_gap1", 32'(q_edge[b+1] - q_edge[b]),   32'd4);
      chk("rl_gap3", 32'(q_edge[b+3] - q_edge[b+2]), 32'd4);

      // BOUNCE at period 1: strobe every cycle, flips at both ends.
      cfg_send(2'd3, 18'h00001, 24'd1, 1'b1, b);
      repeat (37) @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("bn_k0",  32'(q_data[b]),    32'h00001);
      chk("bn_k1",  32'(q_data[b+1]),  32'h00002);
      chk("bn_k17", 32'(q_data[b+17]), 32'h20000);
      chk("bn_k18", 32'(q_data[b+18]), 32'h10000);
      chk("bn_k34", 32'(q_data[b+34]), 32'h00001);
      chk("bn_k35", 32'(q_data[b+35]), 32'h00002);
      chk("bn_gap", 32'(q_edge[b+18] - q_edge[b+17]), 32'd1);
      chk("bn_ready_idle", 32'(cfg_ready), 32'd1);

      // Config accepted in the very cycle the counter expires.
      cfg_send(2'd1, 18'h00001, 24'd8, 1'b1, b);
      repeat (7) @(negedge clk);
      cfg_send(2'd1, 18'h00F00, 24'd8, 1'b1, b2);
      chk("col_writedata", 32'(pio_writedata), 32'h00F00);
      chk("col_cs",        32'(pio_chipselect), 32'd1);
      chk("col_no_step",   32'(b2 - b), 32'd1);

      // enable low for 50 cycles stretches the interval by 50.
      repeat (3) @(negedge clk);
      enable = 1'b0;
      repeat (50) @(negedge clk);
      chk("en_busy_held",  32'(busy), 32'd0);
      chk("en_no_strobe",  32'(q_data.size() - b2), 32'd1);
      enable = 1'b1;
      repeat (10) @(negedge clk);
      chk("col_d0",   32'(q_data[b2]),   32'h00F00);
      chk("col_gap",  32'(q_edge[b2] - q_edge[b]), 32'd8);
      chk("en_d1",    32'(q_data[b2+1]), 32'h01E00);
      chk("en_gap",   32'(q_edge[b2+1] - q_edge[b2]), 32'd58);

      // Asynchronous reset in the middle of a WRITE cycle.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (pio_chipselect) found = 1'b1;
      end
      chk("rw_found", 32'(found), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("rw_cs",      32'(pio_chipselect), 32'd0);
      chk("rw_write_n", 32'(pio_write_n),    32'd1);
      chk("rw_cur",     32'(cur_pattern),    32'd0);
      chk("rw_busy",    32'(busy),           32'd0);
      chk("rw_err",     32'(err),            32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
